dragon_hit_judge: RTL and testbench

//  Responder side of the dragon kill interface. Consumes a dragon sprite's position and show_valid.

---
 rtl/game_pkg.sv | 20 ++
 rtl/bcd_score_counter.sv | 45 ++++
 rtl/dragon_hit_judge.sv | 140 ++++++++++++++
 tb/tb_dragon_hit_judge.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: judge state encodings, default sprite box sizes and screen bounds.
package game_pkg;

  typedef enum logic [1:0] {
    JUDGE_ARMED = 2'd0,
    JUDGE_KILL  = 2'd1,
    JUDGE_DEAD  = 2'd2
  } judge_state_e;

  localparam int D_W_DEF  = 40;
  localparam int D_H_DEF  = 40;
  localparam int B_W_DEF  = 4;
  localparam int B_H_DEF  = 8;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [15:0] SCORE_MAX = 16'h9999;

endpackage

// File: rtl/bcd_score_counter.sv
// 4-digit BCD score counter: +1 per inc pulse, frozen while hold=1, saturates at 9999.
// Result is registered (visible the cycle after inc); shared by all enemy judges.
module bcd_score_counter
  import game_pkg::*;
(
  input  logic        clk_22,
  input  logic        rst,
  input  logic        inc,
  input  logic        hold,
  output logic [15:0] score
);

  logic [15:0] score_q, score_d;
  logic        carry;

  always_comb begin
    score_d = score_q;
    carry   = 1'b0;
    if (inc && !hold && (score_q != SCORE_MAX)) begin
      carry = 1'b1;
      // Ripple the +1 through the digits; a 9 rolls to 0 and passes the carry on.
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (score_q[i*4 +: 4] == 4'd9) begin
            score_d[i*4 +: 4] = 4'd0;
          end else begin
            score_d[i*4 +: 4] = score_q[i*4 +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_22) begin
    if (rst) begin
      score_q <= 16'h0000;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;

endmodule

// File: rtl/dragon_hit_judge.sv
// Dragon/bullet hit judge: registered overlap detect, ARMED/KILL/DEAD kill handshake, BCD score.
// Optional HIT_FLASH_EN macro adds the explosion blink output; otherwise hit_flash is tied 0.
module dragon_hit_judge
  import game_pkg::*;
#(
  parameter int D_W          = D_W_DEF,
  parameter int D_H          = D_H_DEF,
  parameter int B_W          = B_W_DEF,
  parameter int B_H          = B_H_DEF,
  parameter int KILL_TIMEOUT = 8
) (
  input  logic        clk_22,
  input  logic        rst,
  input  logic        pause,
  input  logic [9:0]  d_x,
  input  logic [9:0]  d_y,
  input  logic        show_valid,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  input  logic        b_valid,
  output logic        life_state,
  output logic        bullet_consume,
  output logic [15:0] score,
  output logic        hit_flash
);

  localparam int TW = (KILL_TIMEOUT > 1) ? $clog2(KILL_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(KILL_TIMEOUT - 1);

  judge_state_e  state_q, state_d;
  logic          hit_q, hit_d;
  logic          life_q, life_d;
  logic          cons_q, cons_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          score_inc;
  logic          overlap;

  // Right/bottom edges widened to 11 bits so sprites near 1023 do not wrap.
  logic [10:0] d_right, d_bottom, b_right, b_bottom;
  assign d_right  = {1'b0, d_x} + 11'(D_W);
  assign d_bottom = {1'b0, d_y} + 11'(D_H);
  assign b_right  = {1'b0, b_x} + 11'(B_W);
  assign b_bottom = {1'b0, b_y} + 11'(B_H);

  assign overlap = ({1'b0, b_x} < d_right)  && ({1'b0, d_x} < b_right) &&
                   ({1'b0, b_y} < d_bottom) && ({1'b0, d_y} < b_bottom);

  always_comb begin
    hit_d     = overlap & show_valid & b_valid & ~pause;
    state_d   = state_q;
    life_d    = life_q;
    cons_d    = 1'b0;
    tmo_d     = tmo_q;
    score_inc = 1'b0;
    if (!pause) begin
      case (state_q)
        JUDGE_ARMED: begin
          if (hit_q) begin
            state_d   = JUDGE_KILL;
            life_d    = 1'b1;
            cons_d    = 1'b1;
            score_inc = 1'b1;
            tmo_d     = '0;
          end
        end
        JUDGE_KILL: begin
          // A dropped show_valid and an expiring timeout both land in DEAD.
          if (!show_valid || (tmo_q == TMO_LAST)) begin
            state_d = JUDGE_DEAD;
            life_d  = 1'b0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        JUDGE_DEAD: begin
          life_d = 1'b0;
          if (show_valid) begin
            state_d = JUDGE_ARMED;
            hit_d   = 1'b0;
          end
        end
        default: begin
          state_d = JUDGE_ARMED;
          life_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_22) begin
    if (rst) begin
      state_q <= JUDGE_ARMED;
      hit_q   <= 1'b0;
      life_q  <= 1'b0;
      cons_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      life_q  <= life_d;
      cons_q  <= cons_d;
      tmo_q   <= tmo_d;
    end
  end

  bcd_score_counter u_score (
    .clk_22 (clk_22),
    .rst    (rst),
    .inc    (score_inc),
    .hold   (pause),
    .score  (score)
  );

  assign life_state     = life_q;
  assign bullet_consume = cons_q;

`ifdef HIT_FLASH_EN
  logic [1:0] flash_q, flash_d;

  always_comb begin
    flash_d = flash_q;
    if (!pause) begin
      flash_d = (state_d == JUDGE_ARMED) ? 2'b00 : flash_q + 2'b01;
    end
  end

  always_ff @(posedge clk_22) begin
    if (rst) begin
      flash_q <= 2'b00;
    end else begin
      flash_q <= flash_d;
    end
  end

  assign hit_flash = flash_q[1];
`else
  assign hit_flash = 1'b0;
`endif

endmodule

// File: tb/tb_dragon_hit_judge.sv
// Scoreboard bench for dragon_hit_judge: directed scenarios plus randomized play against a rule model.
module tb_dragon_hit_judge;

  logic        clk_22 = 1'b0;
  logic        rst = 1'b1;
  logic        pause = 1'b0;
  logic [9:0]  d_x = '0, d_y = '0, b_x = '0, b_y = '0;
  logic        show_valid = 1'b0, b_valid = 1'b0;
  logic        life_state, bullet_consume, hit_flash;
  logic [15:0] score;

  dragon_hit_judge dut (
    .clk_22         (clk_22),
    .rst            (rst),
    .pause          (pause),
    .d_x            (d_x),
    .d_y            (d_y),
    .show_valid     (show_valid),
    .b_x            (b_x),
    .b_y            (b_y),
    .b_valid        (b_valid),
    .life_state     (life_state),
    .bullet_consume (bullet_consume),
    .score          (score),
    .hit_flash      (hit_flash)
  );

  always #5 clk_22 = ~clk_22;

  int checks = 0;
  int failures = 0;
  int cycle_no = 0;

  // Expected output after each posedge: {life, consume, flash, score}.
  logic [18:0] exp_q[$];

  // Reference model in game terms.
  int m_mode = 0;     // 0 armed (waiting for hit), 1 kill requested, 2 dead (waiting respawn)
  int m_hit = 0;      // hit detected last tick
  int m_kill_age = 0; // ticks since kill request issued
  int m_score = 0;    // decimal score
  int m_life = 0;
  int m_cons = 0;
  int m_blink = 0;    // ticks spent outside armed

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_tick(input int r, input int p, input int dx, input int dy,
                            input int sv, input int bx, input int by, input int bv);
    int ov, nh, fl;
    if (r != 0) begin
      m_mode = 0; m_hit = 0; m_kill_age = 0; m_score = 0;
      m_life = 0; m_cons = 0; m_blink = 0;
    end else begin
      ov = ((bx < dx + 40) && (dx < bx + 4) && (by < dy + 40) && (dy < by + 8)) ? 1 : 0;
      nh = (ov != 0 && sv != 0 && bv != 0 && p == 0) ? 1 : 0;
      m_cons = 0;
      if (p == 0) begin
        if (m_mode == 0) begin
          if (m_hit != 0) begin
            m_mode = 1; m_life = 1; m_cons = 1; m_kill_age = 0;
            if (m_score < 9999) m_score++;
          end
        end else if (m_mode == 1) begin
          if (sv == 0 || m_kill_age == 7) begin
            m_mode = 2; m_life = 0;
          end else begin
            m_kill_age++;
          end
        end else begin
          if (sv != 0) begin
            m_mode = 0; nh = 0;
          end
        end
        if (m_mode == 0) m_blink = 0;
        else m_blink++;
      end
      m_hit = nh;
    end
`ifdef HIT_FLASH_EN
    fl = (m_blink / 2) % 2;
`else
    fl = 0;
`endif
    exp_q.push_back({m_life[0], m_cons[0], fl[0], to_bcd(m_score)});
  endtask

  task automatic step(input int r, input int p, input int dx, input int dy,
                      input int sv, input int bx, input int by, input int bv);
    rst = r[0]; pause = p[0];
    d_x = dx[9:0]; d_y = dy[9:0]; show_valid = sv[0];
    b_x = bx[9:0]; b_y = by[9:0]; b_valid = bv[0];
    model_tick(r, p, dx % 1024, dy % 1024, sv, bx % 1024, by % 1024, bv);
    @(negedge clk_22);
  endtask

  // Monitor: every output cycle is popped and compared.
  initial begin
    logic [18:0] e;
    forever begin
      @(posedge clk_22);
      #1;
      cycle_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({life_state, bullet_consume, hit_flash, score} !== e) begin
          failures++;
          $display("FAIL outputs cycle=%0d got life=%0b cons=%0b flash=%0b score=%h want life=%0b cons=%0b flash=%0b score=%h",
                   cycle_no, life_state, bullet_consume, hit_flash, score, e[18], e[17], e[16], e[15:0]);
        end
      end
    end
  end

  initial begin
    int dx, dy, bx, by, sv, bv, p, r;

    // Reset state.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (life_state !== 1'b0 || bullet_consume !== 1'b0 || hit_flash !== 1'b0 || score !== 16'h0000) begin
      failures++;
      $display("FAIL reset state life=%0b cons=%0b flash=%0b score=%h",
               life_state, bullet_consume, hit_flash, score);
    end

    // Overlap -> kill request two ticks later; then held until timeout.
    step(0, 0, 100, 100, 1, 120, 120, 1);
    repeat (14) step(0, 0, 100, 100, 1, 0, 0, 0);
    checks++;
    if (life_state !== 1'b0 || bullet_consume !== 1'b0 || score !== 16'h0001) begin
      failures++;
      $display("FAIL expired wait life=%0b cons=%0b score=%h want life=0 cons=0 score=0001",
               life_state, bullet_consume, score);
    end

    // Respawn, hit again, acknowledge by dropping show_valid, respawn with bullet away.
    step(0, 0, 100, 100, 0, 0, 0, 0);
    step(0, 0, 100, 100, 1, 0, 0, 0);
    step(0, 0, 100, 100, 1, 120, 120, 1);
    step(0, 0, 100, 100, 1, 0, 0, 0);
    step(0, 0, 100, 100, 1, 0, 0, 0);
    step(0, 0, 100, 100, 0, 0, 0, 0);
    step(0, 0, 100, 100, 0, 0, 0, 0);
    repeat (4) step(0, 0, 100, 100, 1, 0, 0, 0);

    // Edge miss at b_x = d_x + D_W, then hit at 139; high-coordinate no-false-hit.
    repeat (3) step(0, 0, 100, 100, 1, 140, 100, 1);
    step(0, 0, 100, 100, 1, 139, 100, 1);
    repeat (3) step(0, 0, 100, 100, 0, 0, 0, 0);
    repeat (3) step(0, 0, 1020, 100, 1, 10, 100, 1);
    repeat (3) step(0, 0, 1000, 100, 1, 1020, 100, 1);
    repeat (3) step(0, 0, 100, 100, 0, 0, 0, 0);
    repeat (2) step(0, 0, 100, 100, 1, 0, 0, 0);

    // Pause on the overlap tick drops the hit; pause inside KILL freezes the timeout.
    step(0, 1, 100, 100, 1, 120, 120, 1);
    repeat (3) step(0, 0, 100, 100, 1, 0, 0, 0);
    step(0, 0, 100, 100, 1, 120, 120, 1);
    repeat (3) step(0, 0, 100, 100, 1, 0, 0, 0);
    repeat (6) step(0, 1, 100, 100, 0, 120, 120, 1);
    repeat (8) step(0, 0, 100, 100, 1, 0, 0, 0);

    // Reset in the middle of a kill request.
    repeat (2) step(0, 0, 100, 100, 1, 0, 0, 0);
    step(0, 0, 100, 100, 1, 120, 120, 1);
    repeat (3) step(0, 0, 100, 100, 1, 0, 0, 0);
    step(1, 0, 100, 100, 1, 0, 0, 0);
    repeat (2) step(0, 0, 100, 100, 1, 0, 0, 0);

    // Randomized play, sprites biased to be near each other.
    for (int n = 0; n < 4000; n++) begin
      r  = ($urandom_range(0, 299) == 0) ? 1 : 0;
      p  = ($urandom_range(0, 9) == 0) ? 1 : 0;
      sv = ($urandom_range(0, 5) == 0) ? 0 : 1;
      bv = ($urandom_range(0, 3) == 0) ? 0 : 1;
      dx = $urandom_range(0, 1023);
      dy = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0) begin
        bx = (dx + 1024 + $urandom_range(0, 56) - 10) % 1024;
        by = (dy + 1024 + $urandom_range(0, 60) - 12) % 1024;
      end else begin
        bx = $urandom_range(0, 1023);
        by = $urandom_range(0, 1023);
      end
      step(r, p, dx, dy, sv, bx, by, bv);
    end

    // Drive the score to saturation with a fast hit/ack/respawn loop.
    step(0, 0, 300, 200, 1, 0, 0, 0);
    step(0, 0, 300, 200, 0, 0, 0, 0);
    step(0, 0, 300, 200, 0, 0, 0, 0);
    step(0, 0, 300, 200, 1, 0, 0, 0);
    for (int n = 0; n < 10003; n++) begin
      step(0, 0, 300, 200, 1, 310, 210, 1);
      step(0, 0, 300, 200, 1, 0, 0, 0);
      step(0, 0, 300, 200, 0, 0, 0, 0);
      step(0, 0, 300, 200, 1, 0, 0, 0);
    end
    repeat (3) step(0, 0, 300, 200, 1, 0, 0, 0);

    repeat (3) @(negedge clk_22);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
